dmem_arb: RTL and testbench
===========================

# dmem_arb

Two-port arbiter for the shared data memory (`dmem`). It lets the core's load/store path and a host loader/DMA port share the single-ported data memory. Arbitration is round-robin, with a bounded host lock for burst preload and readback, and the core is stalled while it is denied. It sits between the core's `ls_dec`/`lut_m` memory path, the external host port, and `dmem`, and replaces the direct core→`dmem` connection in `top`.

## Interface
Parameters:
- `AW`, 8, address width
- `DW`, 8, data width
- `MAX_LOCK`, 16, maximum consecutive host-granted cycles under lock before a forced break (≥2)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserting it forces reset state immediately
- `c_req`  in  1  core requests memory this cycle
- `c_we`  in  1  core write (1) / read (0)
- `c_addr`  in  AW  core address
- `c_wdata`  in  DW  core store data
- `c_gnt`  out  1  core granted this cycle (combinational)
- `c_stall`  out  1  `c_req & ~c_gnt`; holds the core PC
- `c_rvalid`  out  1  core read data valid (registered)
- `c_rdata`  out  DW  core read data (registered)
- `h_req`, `h_we`, `h_addr`, `h_wdata`, `h_gnt`, `h_rvalid`, `h_rdata`  same as the core port, host side
- `h_lock`  in  1  host requests burst ownership
- `m_we`  out  1  dmem write enable
- `m_addr`  out  AW  dmem address
- `m_wdata`  out  DW  dmem write data
- `m_rdata`  in  DW  dmem combinational read data

## Operation
- At most one grant per cycle. The `m_*` outputs carry the granted port's `we`/`addr`/`wdata`. With no grant, `m_we=0`, `m_addr=0`, `m_wdata=0`.
- `last_gnt` register: it records the winner of the most recent granted cycle. Its reset value is HOST, so the core wins the first tie.

FSM states are ARB, LOCK and BREAK:
- **ARB:**
  - With a single requester, that requester is granted.
  - With both requesting, the port that is not `last_gnt` is granted.
  - If the host is granted with `h_lock=1`, the next state is LOCK and `lock_cnt` is set to 1.
- **LOCK:**
  - If `h_req & h_lock`: the host is granted, the core is denied, and `lock_cnt` increments.
  - When `lock_cnt==MAX_LOCK`, the next state is BREAK.
  - If `h_lock=0` or `h_req=0`: arbitrate exactly as in ARB this cycle, and the next state is ARB (`lock_cnt` cleared).
- **BREAK:**
  - The host is denied.
  - The core is granted if `c_req`.
  - An empty cycle is allowed if the core is idle.
  - The next state is LOCK with `lock_cnt=0` if `h_lock`, else ARB.
- **Reads:**
  - A granted read (`we=0`) captures `m_rdata` into that port's `rdata` at the edge and pulses `rvalid` for one cycle.
  - `rdata` holds its value until the next read for that port.
  - Writes never assert `rvalid`.
- Simultaneous writes to the same address cannot occur, because only one port is granted per cycle.

## Timing
- Grant is combinational in the request cycle.
- A write commits at the end of the grant cycle.
- Read latency is 1: `rvalid`/`rdata` appear the cycle after the grant.
- Requesters must hold `req`/`we`/`addr`/`wdata` stable until granted. A denied request has no side effects.
- A core loss lasts at most 1 cycle in ARB. Under lock, the worst-case core wait is `MAX_LOCK` cycles.
- Reset values:
  - state ARB, `lock_cnt` 0, `last_gnt` HOST
  - `c_rvalid` 0, `h_rvalid` 0, `c_rdata` 0, `h_rdata` 0
  - grants 0, `c_stall` 0
  - `m_we` 0, `m_addr` 0, `m_wdata` 0
- Reset mid-read: a pending `rvalid` is dropped and not replayed.
- Reset mid-lock: the lock is lost, and the host must reassert `h_lock`.
- Reset deassertion is synchronised by the system. The block has no internal synchroniser.

## Structure
- A shared-package addition in `definitions` holds:
  - `typedef enum logic[1:0] {ARB, LOCK, BREAK} arb_st_t;`
  - `typedef enum logic {GNT_CORE, GNT_HOST} gnt_t;`
- No sub-module is required. An optional `rd_ret` sub-module holds the per-port read-return register pair (the valid/data flop with capture enable) and is instantiated twice.
- The grant decode is a single `always_comb` block. The state, `lock_cnt`, `last_gnt` and read-return registers live in a single `always_ff` block sensitive to `posedge clk or negedge reset`.

## Test plan
All scenarios use `MAX_LOCK=4`.
- **Reset:** assert `reset=0` mid-read → `c_rvalid=0`, `h_rvalid=0`, `m_we=0`, state ARB; after release, a lone `c_req` read of 0x10 (mem=0x5A) → `c_gnt=1` the same cycle, `c_rdata=0x5A` with `c_rvalid=1` the next cycle.
- **Tie round-robin:** both ports request reads for 4 cycles after reset → grants C, H, C, H; `c_stall=1` only on the H cycles.
- **Host write, core read same address:** host writes 0xA5 to 0x20 while core requests a read of 0x20 → the core wins first and gets the old value; the host write commits the next cycle; a core re-read returns 0xA5.
- **Lock with break:** `h_lock=1` with `h_req` held, `c_req` held → host granted 4 cycles, core granted 1 cycle (BREAK), host granted 4 more; `c_stall` is high for exactly 4 of every 5 cycles.
- **Lock release:** drop `h_lock` after 2 locked cycles with both requesting → that cycle arbitrates round-robin (core wins, since `last_gnt`=HOST), and the state returns to ARB.
- **Write no-return:** a granted write with `we=1` → `rvalid` stays 0 and `rdata` is unchanged.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and grant owner.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    BREAK = 2'd2
  } arb_st_t;

  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_HOST = 1'b1
  } gnt_t;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_rd_ret.sv
// Per-port read-return register: captures memory read data on a granted
// read and pulses valid for exactly one cycle. Data holds between reads.
module dmem_arb_rd_ret
  import dmem_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cap,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Valid follows the capture enable; data only updates on a capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_cap;
      if (i_cap) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dmem_arb.sv
// Two-port arbiter for the shared single-ported data memory.
//
//   state | meaning
//   ARB   | round-robin between core and host, last_gnt loses a tie
//   LOCK  | host owns the memory while h_req & h_lock, bounded by MAX_LOCK
//   BREAK | forced one-cycle host denial so a waiting core can get through
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_lock,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int CW = cnt_width(MAX_LOCK);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_st_t       r_st;
  arb_st_t       w_st_nxt;
  logic [CW-1:0] r_lock_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  gnt_t          r_last_gnt;
  logic          w_rr_c;
  logic          w_rr_h;
  logic          w_c_gnt;
  logic          w_h_gnt;
  logic          w_m_we;
  logic [AW-1:0] w_m_addr;
  logic [DW-1:0] w_m_wdata;

  // Grant decode, next-state/lock-count, and memory-port mux.
  always_comb begin
    w_c_gnt   = 1'b0;
    w_h_gnt   = 1'b0;
    w_st_nxt  = r_st;
    w_cnt_nxt = r_lock_cnt;
    w_cnt_inc = r_lock_cnt + CNT_ONE;
    // Round-robin winner: a lone requester wins, a tie goes to the port
    // that did not win the most recent granted cycle.
    w_rr_c    = c_req & (~h_req | (r_last_gnt == GNT_HOST));
    w_rr_h    = h_req & (~c_req | (r_last_gnt == GNT_CORE));

    case (r_st)
      ARB: begin
        w_c_gnt   = w_rr_c;
        w_h_gnt   = w_rr_h;
        w_cnt_nxt = '0;
        if (w_rr_h && h_lock) begin
          // The entry grant is the first locked cycle.
          w_st_nxt  = LOCK;
          w_cnt_nxt = CNT_ONE;
        end
      end
      LOCK: begin
        if (h_req && h_lock) begin
          w_h_gnt   = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_MAX) begin
            w_st_nxt = BREAK;
          end
        end else begin
          // Lock released: behave exactly like ARB for this cycle.
          w_c_gnt   = w_rr_c;
          w_h_gnt   = w_rr_h;
          w_st_nxt  = ARB;
          w_cnt_nxt = '0;
        end
      end
      BREAK: begin
        w_c_gnt   = c_req;
        w_cnt_nxt = '0;
        w_st_nxt  = h_lock ? LOCK : ARB;
      end
      default: begin
        w_st_nxt  = ARB;
        w_cnt_nxt = '0;
      end
    endcase

    // No grant may escape while reset is held.
    if (!reset) begin
      w_c_gnt = 1'b0;
      w_h_gnt = 1'b0;
    end

    w_m_we    = 1'b0;
    w_m_addr  = '0;
    w_m_wdata = '0;
    if (w_c_gnt) begin
      w_m_we    = c_we;
      w_m_addr  = c_addr;
      w_m_wdata = c_wdata;
    end else if (w_h_gnt) begin
      w_m_we    = h_we;
      w_m_addr  = h_addr;
      w_m_wdata = h_wdata;
    end
  end

  // Arbitration state, lock counter and last winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st       <= ARB;
      r_lock_cnt <= '0;
      r_last_gnt <= GNT_HOST;
    end else begin
      r_st       <= w_st_nxt;
      r_lock_cnt <= w_cnt_nxt;
      if (w_c_gnt) begin
        r_last_gnt <= GNT_CORE;
      end else if (w_h_gnt) begin
        r_last_gnt <= GNT_HOST;
      end
    end
  end

  dmem_arb_rd_ret #(.DW(DW)) u_rd_ret_c (
    .clk     (clk),
    .reset   (reset),
    .i_cap   (w_c_gnt & ~c_we),
    .i_data  (m_rdata),
    .o_valid (c_rvalid),
    .o_data  (c_rdata)
  );

  dmem_arb_rd_ret #(.DW(DW)) u_rd_ret_h (
    .clk     (clk),
    .reset   (reset),
    .i_cap   (w_h_gnt & ~h_we),
    .i_data  (m_rdata),
    .o_valid (h_rvalid),
    .o_data  (h_rdata)
  );

  assign c_gnt   = w_c_gnt;
  assign h_gnt   = w_h_gnt;
  assign c_stall = reset & c_req & ~w_c_gnt;
  assign m_we    = w_m_we;
  assign m_addr  = w_m_addr;
  assign m_wdata = w_m_wdata;

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb with MAX_LOCK=4: stimulus pushes expected
// grant records and read data, a negedge monitor pops and compares.
module tb_dmem_arb;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 4;

  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] GC = 2'b01;
  localparam logic [1:0] GH = 2'b10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          c_gnt, c_stall, c_rvalid, h_gnt, h_rvalid, m_we;
  logic [DW-1:0] c_rdata, h_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  logic [DW-1:0] mem [256];

  typedef struct {
    logic          cg;
    logic          hg;
    logic          cs;
    logic          mwe;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
  } gexp_t;

  gexp_t         gnt_q [$];
  logic [DW-1:0] c_q [$];
  logic [DW-1:0] h_q [$];
  int            errors = 0;
  int            checks = 0;
  int            gidx = 0;
  gexp_t         mon_e;
  logic [DW-1:0] mon_d;

  always #5 clk = ~clk;

  dmem_arb #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
    .clk      (clk),
    .reset    (reset),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_stall  (c_stall),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_lock   (h_lock),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // Memory model: combinational read, write at the end of the grant cycle.
  assign m_rdata = mem[m_addr];
  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one request cycle and record what the arbiter must do with it.
  task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                      input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                      input logic hl, input logic [1:0] eg, input logic [7:0] erd);
    gexp_t e;
    @(posedge clk); #1;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd; h_lock = hl;
    e.cg  = eg[0];
    e.hg  = eg[1];
    e.cs  = cr & ~eg[0];
    e.mwe = eg[0] ? cw : (eg[1] ? hw : 1'b0);
    e.ma  = eg[0] ? ca : (eg[1] ? ha : 8'h00);
    e.md  = eg[0] ? cd : (eg[1] ? hd : 8'h00);
    gnt_q.push_back(e);
    if (eg[0] && !cw) c_q.push_back(erd);
    if (eg[1] && !hw) h_q.push_back(erd);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    c_req = 1'b0; h_req = 1'b0; h_lock = 1'b0; c_we = 1'b0; h_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compare grant/memory-port behaviour and read returns.
  always @(negedge clk) begin
    if (gnt_q.size() > 0) begin
      mon_e = gnt_q.pop_front();
      checks++;
      if (c_gnt !== mon_e.cg || h_gnt !== mon_e.hg || c_stall !== mon_e.cs ||
          m_we !== mon_e.mwe || m_addr !== mon_e.ma || m_wdata !== mon_e.md) begin
        errors++;
        $display("FAIL gnt[%0d]: got cg=%b hg=%b cs=%b we=%b a=%h d=%h expected cg=%b hg=%b cs=%b we=%b a=%h d=%h",
                 gidx, c_gnt, h_gnt, c_stall, m_we, m_addr, m_wdata,
                 mon_e.cg, mon_e.hg, mon_e.cs, mon_e.mwe, mon_e.ma, mon_e.md);
      end
      gidx++;
    end
    if (c_rvalid) begin
      checks++;
      if (c_q.size() == 0) begin
        errors++;
        $display("FAIL c_rvalid: got unexpected rvalid data %h expected no return", c_rdata);
      end else begin
        mon_d = c_q.pop_front();
        if (c_rdata !== mon_d) begin
          errors++;
          $display("FAIL c_rdata: got %h expected %h", c_rdata, mon_d);
        end
      end
    end
    if (h_rvalid) begin
      checks++;
      if (h_q.size() == 0) begin
        errors++;
        $display("FAIL h_rvalid: got unexpected rvalid data %h expected no return", h_rdata);
      end else begin
        mon_d = h_q.pop_front();
        if (h_rdata !== mon_d) begin
          errors++;
          $display("FAIL h_rdata: got %h expected %h", h_rdata, mon_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A; mem[8'h11] = 8'hC3; mem[8'h12] = 8'h7E; mem[8'h13] = 8'h19;
    mem[8'h20] = 8'h33; mem[8'h30] = 8'h44; mem[8'h40] = 8'h55;

    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a granted core read: the return is dropped.
    step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, GC, 8'h5A);
    @(negedge clk); #1;
    reset = 1'b0;
    void'(c_q.pop_back());
    #1;
    check("rst_c_gnt", c_gnt, 0);
    check("rst_c_stall", c_stall, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    @(posedge clk); #1;
    check("rst_c_rvalid", c_rvalid, 0);
    check("rst_h_rvalid", h_rvalid, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_h_rdata", h_rdata, 0);
    @(negedge clk);
    c_req = 1'b0;
    reset = 1'b1;
    step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, GC, 8'h5A);
    idle();

    // Tie round-robin from reset: C, H, C, H.
    do_reset();
    step(1, 0, 8'h10, 8'h00, 1, 0, 8'h11, 8'h00, 0, GC, 8'h5A);
    step(1, 0, 8'h12, 8'h00, 1, 0, 8'h11, 8'h00, 0, GH, 8'hC3);
    step(1, 0, 8'h12, 8'h00, 1, 0, 8'h13, 8'h00, 0, GC, 8'h7E);
    step(1, 0, 8'h14, 8'h00, 1, 0, 8'h13, 8'h00, 0, GH, 8'h19);
    idle();

    // Host write vs core read of the same address (last winner = host).
    step(1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hA5, 0, GC, 8'h33);
    step(1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hA5, 0, GH, 8'h00);
    step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, GC, 8'hA5);
    idle();

    // Lock with forced break: H H H H C, twice.
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4)
        step(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 1, GC, 8'h44);
      else
        step(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 1, GH, 8'h55);
    end

    // Two locked cycles, then release: core wins, back to round-robin.
    step(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 1, GH, 8'h55);
    step(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 1, GH, 8'h55);
    step(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 0, GC, 8'h44);
    step(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 0, GH, 8'h55);
    idle();

    // Writes produce no read return and leave rdata alone.
    step(1, 1, 8'h50, 8'h99, 0, 0, 8'h00, 8'h00, 0, GC, 8'h00);
    idle();
    check("wr_c_rvalid", c_rvalid, 0);
    check("wr_c_rdata", c_rdata, 8'h44);
    step(0, 0, 8'h00, 8'h00, 1, 1, 8'h51, 8'h77, 0, GH, 8'h00);
    idle();
    check("wr_h_rvalid", h_rvalid, 0);
    check("wr_h_rdata", h_rdata, 8'h55);
    step(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 0, GC, 8'h99);
    step(0, 0, 8'h00, 8'h00, 1, 0, 8'h51, 8'h00, 0, GH, 8'h77);
    idle();
    idle();
    @(negedge clk); #1;

    check("gnt_q_drained", gnt_q.size(), 0);
    check("c_q_drained", c_q.size(), 0);
    check("h_q_drained", h_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
